sysid_reader: RTL and testbench

SYSID_READER -- requirements
Module: sysid_reader

---
 rtl/sysid_reader_defs.sv | 15 +
 rtl/sysid_timeout_cnt.sv | 38 +++
 rtl/sysid_reader.sv | 137 +++++++++++++
 tb/tb_sysid_reader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_reader_defs.sv
// Shared constants for the sysid reader: FSM state encodings and the
// Avalon word addresses of the two sysid registers.
package sysid_reader_defs;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RD_ID = 2'd1;
  localparam state_t ST_RD_TS = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_timeout_cnt.sv
// Per-read stall counter: counts waitrequest-high cycles and flags the cycle
// on which the read must be abandoned.
module sysid_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Saturates at LIMIT so a long stall can never wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign expired = inc && (cnt_q == LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sysid_reader.sv
// Reads the sysid ID and timestamp words over Avalon-MM, compares them with
// the expected build values and reports pass/fail/timeout.
module sysid_reader
  import sysid_reader_defs::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd2097841511,
  parameter logic [31:0] EXPECTED_TS    = 32'd1327086805,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned AUTO_START     = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic [31:0] av_readdata,
  input  logic        av_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic AUTO_EN = (AUTO_START != 0);

  state_t      state_q, state_d;
  logic        auto_q, auto_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  logic        rd_active;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        expired;

  assign rd_active = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);

  // Clearing on the ID capture edge makes the counter start from zero in RD_TS
  // without a dependency on the next-state logic.
  assign cnt_clr = !rd_active || ((state_q == ST_RD_ID) && !av_waitrequest);
  assign cnt_inc = rd_active && av_waitrequest;

  sysid_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    auto_d     = auto_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    case (state_q)
      ST_IDLE: begin
        if (start || auto_q) begin
          state_d = ST_RD_ID;
          auto_d  = 1'b0;
        end
      end
      ST_RD_ID: begin
        if (!av_waitrequest) begin
          id_value_d = av_readdata;
          state_d    = ST_RD_TS;
        end else if (expired) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
        end
      end
      ST_RD_TS: begin
        if (!av_waitrequest) begin
          ts_value_d = av_readdata;
          state_d    = ST_DONE;
          id_ok_d    = (id_value_q == EXPECTED_ID);
          ts_ok_d    = (av_readdata == EXPECTED_TS);
          timeout_d  = 1'b0;
        end else if (expired) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      auto_q     <= AUTO_EN;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      state_q    <= state_d;
      auto_q     <= auto_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  // Bus outputs decode straight from the state register, so they are glitch-free
  // and address returns to zero whenever no read is in flight.
  assign av_read    = rd_active;
  assign av_address = (state_q == ST_RD_TS) ? ADDR_TS : ADDR_ID;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign id_ok      = id_ok_q;
  assign ts_ok      = ts_ok_q;
  assign timeout    = timeout_q;
  assign id_value   = id_value_q;
  assign ts_value   = ts_value_q;

endmodule

// File: tb/tb_sysid_reader.sv
// Directed bench for sysid_reader: default instance for the main flows and a
// short-timeout instance for the stuck-slave case.
module tb_sysid_reader;

  localparam logic [31:0] ID_W = 32'd2097841511;
  localparam logic [31:0] TS_W = 32'd1327086805;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;

  logic        start_a, addr_a, read_a, wr_a, busy_a, done_a;
  logic        id_ok_a, ts_ok_a, tmo_a;
  logic [31:0] rdata_a, id_val_a, ts_val_a, id_word_a, ts_word_a;

  logic        start_b, addr_b, read_b, wr_b, busy_b, done_b;
  logic        id_ok_b, ts_ok_b, tmo_b;
  logic [31:0] rdata_b, id_val_b, ts_val_b;

  assign rdata_a = addr_a ? ts_word_a : id_word_a;
  assign rdata_b = addr_b ? TS_W : ID_W;

  sysid_reader dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a),
    .av_address(addr_a), .av_read(read_a), .av_readdata(rdata_a),
    .av_waitrequest(wr_a), .busy(busy_a), .done(done_a),
    .id_ok(id_ok_a), .ts_ok(ts_ok_a), .timeout(tmo_a),
    .id_value(id_val_a), .ts_value(ts_val_a)
  );

  sysid_reader #(.TIMEOUT_CYCLES(8), .AUTO_START(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b),
    .av_address(addr_b), .av_read(read_b), .av_readdata(rdata_b),
    .av_waitrequest(wr_b), .busy(busy_b), .done(done_b),
    .id_ok(id_ok_b), .ts_ok(ts_ok_b), .timeout(tmo_b),
    .id_value(id_val_b), .ts_value(ts_val_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int dones;
    reset_n   = 1'b0;
    start_a   = 1'b0;
    start_b   = 1'b0;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    id_word_a = ID_W;
    ts_word_a = TS_W;
    tick();
    tick();

    // Reset values
    chk("rst_read",  32'(read_a), 32'd0);
    chk("rst_addr",  32'(addr_a), 32'd0);
    chk("rst_busy",  32'(busy_a), 32'd0);
    chk("rst_done",  32'(done_a), 32'd0);
    chk("rst_idok",  32'(id_ok_a), 32'd0);
    chk("rst_tmo",   32'(tmo_a), 32'd0);
    chk("rst_idval", id_val_a, 32'd0);
    chk("rst_tsval", ts_val_a, 32'd0);

    // Auto start after reset release; a start during busy must not queue
    reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      start_a = (i == 0);
      if (i == 0) chk("auto_busy", 32'(busy_a), 32'd1);
      if (i == 2) chk("auto_done_c3", 32'(done_a), 32'd1);
      if (done_a) dones++;
    end
    start_a = 1'b0;
    chk("auto_one_done", 32'(dones), 32'd1);
    chk("auto_idok", 32'(id_ok_a), 32'd1);
    chk("auto_tsok", 32'(ts_ok_a), 32'd1);
    chk("auto_idle", 32'(busy_a), 32'd0);

    // Nominal check with zero-wait slave
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("c1_read", 32'(read_a), 32'd1);
    chk("c1_addr", 32'(addr_a), 32'd0);
    tick();
    chk("c2_read", 32'(read_a), 32'd1);
    chk("c2_addr", 32'(addr_a), 32'd1);
    tick();
    chk("c3_done", 32'(done_a), 32'd1);
    chk("c3_read", 32'(read_a), 32'd0);
    chk("c3_addr", 32'(addr_a), 32'd0);
    tick();
    chk("c4_done",  32'(done_a), 32'd0);
    chk("c4_busy",  32'(busy_a), 32'd0);
    chk("c4_idok",  32'(id_ok_a), 32'd1);
    chk("c4_tsok",  32'(ts_ok_a), 32'd1);
    chk("c4_tmo",   32'(tmo_a), 32'd0);
    chk("c4_idval", id_val_a, ID_W);
    chk("c4_tsval", ts_val_a, TS_W);

    // Wrong ID word
    id_word_a = 32'h0000_0000;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    chk("badid_done", 32'(done_a), 32'd1);
    tick();
    chk("badid_idok",  32'(id_ok_a), 32'd0);
    chk("badid_tsok",  32'(ts_ok_a), 32'd1);
    chk("badid_idval", id_val_a, 32'd0);
    id_word_a = ID_W;

    // Five stall cycles on each read
    start_a = 1'b1;
    wr_a    = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      wr_a = !((c == 6) || (c == 12));
      chk("stall_read", 32'(read_a), 32'd1);
      chk("stall_addr", 32'(addr_a), (c <= 6) ? 32'd0 : 32'd1);
      chk("stall_nodone", 32'(done_a), 32'd0);
      tick();
    end
    wr_a = 1'b0;
    chk("stall_done_c13", 32'(done_a), 32'd1);
    tick();
    chk("stall_idok", 32'(id_ok_a), 32'd1);
    chk("stall_tsok", 32'(ts_ok_a), 32'd1);

    // Short-timeout instance: good run, then stuck slave, then recovery
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    tick();
    chk("b_good_done", 32'(done_b), 32'd1);
    tick();
    chk("b_good_idok", 32'(id_ok_b), 32'd1);

    wr_b    = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("tmo_read", 32'(read_b), 32'd1);
      chk("tmo_addr", 32'(addr_b), 32'd0);
      tick();
    end
    chk("tmo_read_drop", 32'(read_b), 32'd0);
    chk("tmo_done", 32'(done_b), 32'd1);
    chk("tmo_flag", 32'(tmo_b), 32'd1);
    tick();
    chk("tmo_idok",  32'(id_ok_b), 32'd0);
    chk("tmo_tsok",  32'(ts_ok_b), 32'd0);
    chk("tmo_idval", id_val_b, ID_W);
    chk("tmo_tsval", ts_val_b, TS_W);
    chk("tmo_hold",  32'(tmo_b), 32'd1);
    chk("tmo_idle",  32'(busy_b), 32'd0);

    wr_b    = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    tick();
    tick();
    chk("rec_tmo_clr", 32'(tmo_b), 32'd0);
    chk("rec_idok",    32'(id_ok_b), 32'd1);

    // Reset pulse during RD_TS
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    chk("mid_in_rdts", 32'(addr_a), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_read",  32'(read_a), 32'd0);
    chk("mid_busy",  32'(busy_a), 32'd0);
    chk("mid_done",  32'(done_a), 32'd0);
    chk("mid_idok",  32'(id_ok_a), 32'd0);
    chk("mid_tsok",  32'(ts_ok_a), 32'd0);
    chk("mid_idval", id_val_a, 32'd0);
    chk("mid_tsval", ts_val_a, 32'd0);
    tick();
    chk("mid_hold_done", 32'(done_a), 32'd0);
    reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done_a) dones++;
    end
    chk("mid_rerun_done", 32'(dones), 32'd1);
    chk("mid_rerun_idok", 32'(id_ok_a), 32'd1);
    chk("mid_rerun_tsok", 32'(ts_ok_a), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
